// File: rtl/tx_resp_ctrl_if.sv
// -----------------------------------------------------------------------------
// tx_resp_ctrl_if
// Purpose : groups the response sources (register file, ALU), the UART
//           transmitter handshake and the status flag of tx_resp_ctrl.
// Signals : RdData/RdData_Valid   register-file read data + strobe
//           ALU_OUT/OUT_Valid     ALU result + strobe
//           TX_Busy               UART transmitter busy
//           TX_P_Data/TX_D_VLD    byte offered to the UART + valid
//           Overrun               sticky pending-response overwrite flag
// Modports: master drives the sources and TX_Busy, slave is the controller.
// -----------------------------------------------------------------------------
interface tx_resp_ctrl_if #(
  parameter int unsigned BusWidth = 8
);
  logic [BusWidth-1:0]   RdData;
  logic                  RdData_Valid;
  logic [2*BusWidth-1:0] ALU_OUT;
  logic                  OUT_Valid;
  logic                  TX_Busy;
  logic [BusWidth-1:0]   TX_P_Data;
  logic                  TX_D_VLD;
  logic                  Overrun;

  modport master (
    output RdData, RdData_Valid, ALU_OUT, OUT_Valid, TX_Busy,
    input  TX_P_Data, TX_D_VLD, Overrun
  );

  modport slave (
    input  RdData, RdData_Valid, ALU_OUT, OUT_Valid, TX_Busy,
    output TX_P_Data, TX_D_VLD, Overrun
  );
endinterface

// File: rtl/tx_resp_ctrl.sv
// -----------------------------------------------------------------------------
// tx_resp_ctrl
// Purpose : serialises register-file and ALU responses into bytes for a UART
//           transmitter. Each source has one pending slot; a round-robin
//           arbiter claims a slot into a frame register which is then sent
//           byte by byte using the TX_Busy handshake.
// Ports   : CLK  system clock (rising edge)
//           RST  asynchronous active-low reset
//           bus  tx_resp_ctrl_if.slave (sources, UART handshake, Overrun)
// Config  : TX_FRAME_CHK_EN appends an XOR trailer byte to every frame.
// -----------------------------------------------------------------------------
module tx_resp_ctrl #(
  parameter int unsigned BusWidth = 8
) (
  input  logic          CLK,
  input  logic          RST,
  tx_resp_ctrl_if.slave bus
);

`ifdef TX_FRAME_CHK_EN
  localparam int unsigned MaxBytes = 3;
`else
  localparam int unsigned MaxBytes = 2;
`endif
  localparam int unsigned IdxW   = 2;
  localparam int unsigned FrameW = MaxBytes * BusWidth;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    WAIT_HI = 2'd2,
    WAIT_LO = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic                  r_rf_flag;
  logic [BusWidth-1:0]   r_rf_data;
  logic                  r_alu_flag;
  logic [2*BusWidth-1:0] r_alu_data;
  logic                  r_last_alu;
  logic                  r_overrun;

  logic [FrameW-1:0]     r_frame;
  logic [IdxW-1:0]       r_len;
  logic [IdxW-1:0]       r_idx;
  logic                  r_vld;
  logic [BusWidth-1:0]   r_data;

  logic                  w_pick_rf;
  logic                  w_claim_rf;
  logic                  w_claim_alu;
  logic                  w_ovr_set;
  logic [IdxW-1:0]       w_idx_inc;
  logic                  w_more;
  logic [BusWidth-1:0]   w_next_byte;
  logic [FrameW-1:0]     w_frame_sel;
  logic [IdxW-1:0]       w_len_sel;
  logic                  w_load;
  logic                  w_vld_nxt;
  logic [BusWidth-1:0]   w_data_nxt;
  logic [IdxW-1:0]       w_idx_nxt;

  // Round-robin: on a tie the RF wins only if the ALU was served last.
  assign w_pick_rf   = r_rf_flag && (!r_alu_flag || r_last_alu);
  assign w_claim_rf  = (r_state == IDLE) && w_pick_rf;
  assign w_claim_alu = (r_state == IDLE) && r_alu_flag && !w_pick_rf;

  // A strobe into an occupied slot that is not leaving this cycle loses data.
  assign w_ovr_set = (bus.RdData_Valid && r_rf_flag  && !w_claim_rf) ||
                     (bus.OUT_Valid    && r_alu_flag && !w_claim_alu);

  assign w_idx_inc = r_idx + IdxW'(1);
  assign w_more    = (w_idx_inc < r_len);

  // Frame image and length of the slot being claimed.
  always_comb begin : frame_build
    w_frame_sel = '0;
    w_len_sel   = '0;
`ifdef TX_FRAME_CHK_EN
    if (w_claim_alu) begin
      w_frame_sel = {r_alu_data[BusWidth-1:0] ^ r_alu_data[2*BusWidth-1:BusWidth],
                     r_alu_data};
      w_len_sel   = IdxW'(3);
    end else begin
      w_frame_sel = {{BusWidth{1'b0}}, r_rf_data, r_rf_data};
      w_len_sel   = IdxW'(2);
    end
`else
    if (w_claim_alu) begin
      w_frame_sel = r_alu_data;
      w_len_sel   = IdxW'(2);
    end else begin
      w_frame_sel = {{BusWidth{1'b0}}, r_rf_data};
      w_len_sel   = IdxW'(1);
    end
`endif
  end

  // Byte that follows the current one inside the frame register.
  always_comb begin : byte_sel
    w_next_byte = '0;
    for (int unsigned k = 0; k < MaxBytes; k++) begin
      if (w_idx_inc == IdxW'(k)) begin
        w_next_byte = r_frame[k*BusWidth +: BusWidth];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin : next_state
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (r_rf_flag || r_alu_flag) w_state_nxt = SEND;
      SEND:    if (!bus.TX_Busy)            w_state_nxt = WAIT_HI;
      WAIT_HI: if (bus.TX_Busy)             w_state_nxt = WAIT_LO;
      WAIT_LO: if (!bus.TX_Busy)            w_state_nxt = w_more ? SEND : IDLE;
      default:                              w_state_nxt = IDLE;
    endcase
  end

  // FSM output logic: next values of the registered TX outputs and frame control.
  always_comb begin : next_out
    w_vld_nxt  = r_vld;
    w_data_nxt = r_data;
    w_idx_nxt  = r_idx;
    w_load     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_claim_rf) begin
          w_vld_nxt  = 1'b1;
          w_data_nxt = r_rf_data;
          w_idx_nxt  = '0;
          w_load     = 1'b1;
        end else if (w_claim_alu) begin
          w_vld_nxt  = 1'b1;
          w_data_nxt = r_alu_data[BusWidth-1:0];
          w_idx_nxt  = '0;
          w_load     = 1'b1;
        end
      end
      SEND: begin
        if (!bus.TX_Busy) w_vld_nxt = 1'b0;
      end
      WAIT_LO: begin
        if (!bus.TX_Busy && w_more) begin
          w_vld_nxt  = 1'b1;
          w_data_nxt = w_next_byte;
          w_idx_nxt  = w_idx_inc;
        end
      end
      default: ;
    endcase
  end

  // Frame register, byte index and registered TX outputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_frame    <= '0;
      r_len      <= '0;
      r_idx      <= '0;
      r_vld      <= 1'b0;
      r_data     <= '0;
      r_last_alu <= 1'b1;
    end else begin
      r_vld  <= w_vld_nxt;
      r_data <= w_data_nxt;
      r_idx  <= w_idx_nxt;
      if (w_load) begin
        r_frame    <= w_frame_sel;
        r_len      <= w_len_sel;
        r_last_alu <= w_claim_alu;
      end
    end
  end

  // Pending slots capture in every state; a same-cycle strobe re-arms a claimed slot.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_rf_flag  <= 1'b0;
      r_rf_data  <= '0;
      r_alu_flag <= 1'b0;
      r_alu_data <= '0;
      r_overrun  <= 1'b0;
    end else begin
      if (bus.RdData_Valid) begin
        r_rf_data <= bus.RdData;
        r_rf_flag <= 1'b1;
      end else if (w_claim_rf) begin
        r_rf_flag <= 1'b0;
      end
      if (bus.OUT_Valid) begin
        r_alu_data <= bus.ALU_OUT;
        r_alu_flag <= 1'b1;
      end else if (w_claim_alu) begin
        r_alu_flag <= 1'b0;
      end
      if (w_ovr_set) r_overrun <= 1'b1;
    end
  end

  assign bus.TX_P_Data = r_data;
  assign bus.TX_D_VLD  = r_vld;
  assign bus.Overrun   = r_overrun;

endmodule

// File: tb/tb_tx_resp_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tx_resp_ctrl
// Purpose : self-checking bench for tx_resp_ctrl. A UART model accepts bytes
//           and goes busy for 10 cycles; expected byte streams come from a
//           frame-level model (payload bytes, optional XOR trailer, round-robin
//           order on simultaneous strobes).
// -----------------------------------------------------------------------------
module tb_tx_resp_ctrl;
  localparam int unsigned BW = 8;

  logic CLK = 1'b0;
  logic RST = 1'b0;

  tx_resp_ctrl_if #(.BusWidth(BW)) bus ();

  tx_resp_ctrl #(.BusWidth(BW)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int  acc_cnt  = 0;
  int  busy_cnt = 0;
  bit  acc_pend = 1'b0;
  bit  hold     = 1'b0;
  bit  model_last_alu = 1'b1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // UART model: sees DUT outputs mid-cycle, so an accept observed here happens
  // at the next rising edge; busy rises the cycle after that for 10 cycles.
  always @(negedge CLK) begin
    if (!RST) begin
      busy_cnt    = 0;
      acc_pend    = 1'b0;
      bus.TX_Busy = 1'b0;
    end else begin
      if (acc_pend) begin
        acc_pend = 1'b0;
        busy_cnt = 10;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
      end
      bus.TX_Busy = hold || (busy_cnt > 0);
      if (bus.TX_D_VLD && !bus.TX_Busy) begin
        got_q.push_back(bus.TX_P_Data);
        acc_pend = 1'b1;
        acc_cnt++;
      end
    end
  end

  function automatic void exp_rf(input logic [7:0] d);
    exp_q.push_back(d);
`ifdef TX_FRAME_CHK_EN
    exp_q.push_back(d);
`endif
    model_last_alu = 1'b0;
  endfunction

  function automatic void exp_alu(input logic [15:0] v);
    exp_q.push_back(v[7:0]);
    exp_q.push_back(v[15:8]);
`ifdef TX_FRAME_CHK_EN
    exp_q.push_back(v[7:0] ^ v[15:8]);
`endif
    model_last_alu = 1'b1;
  endfunction

  function automatic void exp_pair(input logic [7:0] d, input logic [15:0] v);
    if (model_last_alu) begin
      exp_rf(d);
      exp_alu(v);
    end else begin
      exp_alu(v);
      exp_rf(d);
    end
  endfunction

  // Present strobes for one cycle; returns 1 time unit after the sampling edge.
  task automatic strobe(input bit do_rf, input logic [7:0] rd, input bit do_alu, input logic [15:0] av);
    @(negedge CLK);
    bus.RdData       = rd;
    bus.RdData_Valid = do_rf;
    bus.ALU_OUT      = av;
    bus.OUT_Valid    = do_alu;
    @(posedge CLK);
    #1;
    bus.RdData_Valid = 1'b0;
    bus.OUT_Valid    = 1'b0;
  endtask

  task automatic wait_vld(input string tag);
    int k = 0;
    while (!bus.TX_D_VLD && k < 200) begin
      @(posedge CLK);
      #1;
      k++;
    end
    check_eq({tag, "_vld_seen"}, 32'(bus.TX_D_VLD), 32'd1);
  endtask

  task automatic drain(input string tag);
    int k = 0;
    int n;
    while (got_q.size() < exp_q.size() && k < 3000) begin
      @(posedge CLK);
      #1;
      k++;
    end
    repeat (30) @(posedge CLK);
    #1;
    check_eq({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check_eq($sformatf("%s_b%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int a0;
    int k;
    bit ok;
    logic [7:0]  saved;
    logic [7:0]  rd;
    logic [15:0] av;
    int kind;

    bus.RdData       = '0;
    bus.RdData_Valid = 1'b0;
    bus.ALU_OUT      = '0;
    bus.OUT_Valid    = 1'b0;

    // Reset values
    repeat (3) @(posedge CLK);
    #1;
    check_eq("rst_vld",  32'(bus.TX_D_VLD),  32'd0);
    check_eq("rst_data", 32'(bus.TX_P_Data), 32'd0);
    check_eq("rst_ovr",  32'(bus.Overrun),   32'd0);
    @(posedge CLK);
    #3 RST = 1'b1;
    repeat (2) @(posedge CLK);

    // Single RF byte with latency
    strobe(1'b1, 8'h5A, 1'b0, 16'h0);
    lat = 1;
    while (!bus.TX_D_VLD && lat < 20) begin
      @(posedge CLK);
      #1;
      lat++;
    end
    check_eq("rf_latency", 32'(lat), 32'd2);
    check_eq("rf_first_byte", 32'(bus.TX_P_Data), 32'h5A);
    exp_rf(8'h5A);
    drain("rf5a");

    // ALU frame
    strobe(1'b0, 8'h0, 1'b1, 16'h1234);
    exp_alu(16'h1234);
    drain("alu1234");

    // Simultaneous pairs: RF first both times
    strobe(1'b1, 8'h11, 1'b1, 16'hABCD);
    exp_pair(8'h11, 16'hABCD);
    drain("pair1");
    strobe(1'b1, 8'h22, 1'b1, 16'h9876);
    exp_pair(8'h22, 16'h9876);
    drain("pair2");

    // Busy held during SEND
    hold = 1'b1;
    @(posedge CLK);
    strobe(1'b1, 8'h3C, 1'b0, 16'h0);
    wait_vld("hold");
    saved = bus.TX_P_Data;
    a0 = acc_cnt;
    ok = 1'b1;
    repeat (20) begin
      @(posedge CLK);
      #1;
      if (!bus.TX_D_VLD || bus.TX_P_Data !== saved) ok = 1'b0;
    end
    check_eq("hold_stable", 32'(ok), 32'd1);
    check_eq("hold_no_acc", 32'(acc_cnt - a0), 32'd0);
    check_eq("hold_data", 32'(saved), 32'h3C);
    hold = 1'b0;
    exp_rf(8'h3C);
    drain("hold");

    // Overrun: two RF strobes during an ALU frame
    strobe(1'b0, 8'h0, 1'b1, 16'hBEEF);
    wait_vld("ovr");
    strobe(1'b1, 8'h01, 1'b0, 16'h0);
    check_eq("ovr_after_one", 32'(bus.Overrun), 32'd0);
    strobe(1'b1, 8'h02, 1'b0, 16'h0);
    check_eq("ovr_set", 32'(bus.Overrun), 32'd1);
    exp_alu(16'hBEEF);
    exp_rf(8'h02);
    drain("ovr");
    check_eq("ovr_sticky", 32'(bus.Overrun), 32'd1);

    // Reset in WAIT_HI of an ALU frame
    strobe(1'b0, 8'h0, 1'b1, 16'h5678);
    a0 = acc_cnt;
    k = 0;
    while (acc_cnt == a0 && k < 200) begin
      @(posedge CLK);
      #1;
      k++;
    end
    check_eq("mid_acc_seen", 32'(acc_cnt - a0), 32'd1);
    #1 RST = 1'b0;
    #1;
    check_eq("mid_rst_vld",  32'(bus.TX_D_VLD),  32'd0);
    check_eq("mid_rst_data", 32'(bus.TX_P_Data), 32'd0);
    check_eq("mid_rst_ovr",  32'(bus.Overrun),   32'd0);
    @(posedge CLK);
    #3 RST = 1'b1;
    repeat (40) @(posedge CLK);
    #1;
    check_eq("mid_rst_count", 32'(got_q.size()), 32'd1);
    if (got_q.size() > 0) check_eq("mid_rst_byte0", 32'(got_q[0]), 32'h78);
    got_q.delete();
    exp_q.delete();
    model_last_alu = 1'b1;

    // Randomized frames
    for (int it = 0; it < 16; it++) begin
      kind = $urandom_range(0, 2);
      rd   = 8'($urandom);
      av   = 16'($urandom);
      repeat ($urandom_range(0, 3)) @(posedge CLK);
      case (kind)
        0: begin strobe(1'b1, rd, 1'b0, av); exp_rf(rd); end
        1: begin strobe(1'b0, rd, 1'b1, av); exp_alu(av); end
        default: begin strobe(1'b1, rd, 1'b1, av); exp_pair(rd, av); end
      endcase
      drain($sformatf("rnd%0d", it));
    end
    check_eq("rnd_no_ovr", 32'(bus.Overrun), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/tx_resp_ctrl.md
TX_RESP_CTRL -- requirements
Module: tx_resp_ctrl

Interface
REQ-001 SHALL have parameter BusWidth, default 8, width of register-file read data and of each UART byte.
REQ-002 SHALL have port CLK, input, 1, the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port RST, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have port RdData, input, BusWidth, register-file read data.
REQ-005 SHALL have port RdData_Valid, input, 1, one-cycle strobe qualifying RdData.
REQ-006 SHALL have port ALU_OUT, input, 2*BusWidth, ALU result.
REQ-007 SHALL have port OUT_Valid, input, 1, one-cycle strobe qualifying ALU_OUT.
REQ-008 SHALL have port TX_Busy, input, 1, UART transmitter busy.
REQ-009 SHALL have port TX_P_Data, output, BusWidth, byte offered to the UART transmitter, registered.
REQ-010 SHALL have port TX_D_VLD, output, 1, TX_P_Data valid, registered.
REQ-011 SHALL have port Overrun, output, 1, sticky flag: a pending response was overwritten before transmission.

Function
REQ-012 SHALL hold one pending slot per source (flag plus data); a sampled RdData_Valid/OUT_Valid loads the slot and sets its flag at that edge.
REQ-013 SHALL set Overrun when a strobe arrives while that source's flag is set and the slot is not being claimed in the same cycle; new data overwrites old data.
REQ-014 SHALL treat a strobe in the same cycle a slot is claimed as a fresh capture: flag stays set and Overrun is unchanged.
REQ-015 SHALL use FSM states IDLE, SEND, WAIT_HI, WAIT_LO; a byte index plus a frame-length count select the byte being sent.
REQ-016 IDLE: if any flag is set, SHALL claim one slot, copy its data into a frame register, clear its flag, load byte 0 into TX_P_Data, set TX_D_VLD, and go to SEND.
REQ-017 SHALL arbitrate round-robin when both flags are set: serve the source not served last; after reset the last-served source is the ALU, so the RF wins the first tie.
REQ-018 RF frame SHALL be 1 byte (RdData); ALU frame SHALL be 2 bytes, ALU_OUT[BusWidth-1:0] first, then ALU_OUT[2*BusWidth-1:BusWidth].
REQ-019 SEND: TX_D_VLD and TX_P_Data SHALL hold stable until a cycle with TX_Busy=0 (acceptance); TX_D_VLD SHALL then deassert and the FSM goes to WAIT_HI.
REQ-020 WAIT_HI SHALL wait for TX_Busy=1, then go to WAIT_LO; WAIT_LO SHALL wait for TX_Busy=0.
REQ-021 On leaving WAIT_LO SHALL load the next byte and re-enter SEND with TX_D_VLD=1 if bytes remain, else go to IDLE; back-to-back frames therefore pass through IDLE for one cycle.
REQ-022 Latency: with the FSM in IDLE and TX_Busy=0, TX_D_VLD SHALL first assert 2 cycles after the strobe is sampled.
REQ-023 Pending slots SHALL keep capturing in every state; a claimed frame SHALL never be altered by new strobes.

Reset
REQ-024 RST low SHALL immediately force: FSM IDLE, TX_D_VLD=0, TX_P_Data=0, Overrun=0, both flags 0, last-served=ALU, byte index 0.
REQ-025 Reset mid-frame SHALL abandon the frame and both pending slots; no partial byte resumes after release.

Configuration
REQ-026 With macro TX_FRAME_CHK_EN defined, each frame SHALL append one trailer byte equal to the XOR of its payload bytes; RF frames are 2 bytes and ALU frames are 3.
REQ-027 Without TX_FRAME_CHK_EN, frames SHALL be payload only, as in REQ-018, and no checksum logic is present.

Verification
REQ-028 RdData=0x5A with strobe and TX_Busy model (busy 1 cycle after acceptance, for 10 cycles) -> single byte 0x5A, TX_D_VLD 2 cycles after strobe; with TX_FRAME_CHK_EN the bytes are 0x5A, 0x5A.
REQ-029 ALU_OUT=0x1234 strobe -> bytes 0x34 then 0x12, each accepted once; with TX_FRAME_CHK_EN a third byte 0x26.
REQ-030 RdData=0x11 and ALU_OUT=0xABCD strobed in the same cycle -> 0x11, then 0xCD, then 0xAB; a second simultaneous pair -> the RF frame precedes the ALU frame again (ALU was last served).
REQ-031 Hold TX_Busy=1 for 20 cycles during SEND -> TX_D_VLD and TX_P_Data stay stable throughout, and exactly one acceptance occurs.
REQ-032 Two RdData strobes (0x01, 0x02) while a frame is in progress -> Overrun=1, only 0x02 is sent; the flag stays set until reset.
REQ-033 Assert RST during WAIT_HI of an ALU frame -> outputs reach their reset values with no clock edge, and no further bytes are sent after release.
